// File: rtl/des_subkey_gen.sv
// des_subkey_gen
//   Sequential DES key schedule. After a start, presents one 48-bit round
//   subkey per accepted valid/ready transfer, 16 in total. Encrypt order is
//   K1..K16 using left rotations. Decrypt order is K16..K1, rebuilt on the fly
//   with right rotations, so no subkey store is kept.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   begin a schedule (sampled only while idle)
//   decrypt    in   1   0 = K1..K16, 1 = K16..K1 (sampled with start)
//   key_in     in   64  DES key, bit 63 = DES bit 1 (sampled with start)
//   sk_ready   in   1   consumer accepts the presented subkey
//   sk_valid   out  1   subkey / round_idx / sk_last are valid
//   subkey     out  48  PC-2 output, bit 47 = DES bit 1
//   round_idx  out  4   DES round number minus 1 of the presented subkey
//   sk_last    out  1   presented subkey is the 16th of the schedule
//   busy       out  1   schedule in progress
//   key_err    out  1   one-cycle pulse: start refused on a key parity fault
module des_subkey_gen #(
  parameter bit PARITY_CHECK = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic        sk_ready,
  output logic        sk_valid,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        sk_last,
  output logic        busy,
  output logic        key_err
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  // DES bit numbers (1 = MSB of key_in); first 28 entries form C, last 28 form D.
  // Parity bits 8,16,..,64 never appear here.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Positions in the 56-bit {C,D} (1 = MSB of C).
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-PC1_TAB[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2_TAB[i]];
    end
    return r;
  endfunction

  // Odd parity required in every byte.
  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ok = ok & (^k[8*i +: 8]);
    end
    return ok;
  endfunction

  // Shift amount for 0-based round index: rounds 1,2,9,16 shift by one.
  function automatic logic shift_is_two(input logic [3:0] idx);
    logic two;
    case (idx)
      4'd0, 4'd1, 4'd8, 4'd15: two = 1'b0;
      default:                 two = 1'b1;
    endcase
    return two;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  logic [0:0]  state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        dec_q, dec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sk_valid_q, sk_valid_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  round_idx_q, round_idx_d;
  logic        sk_last_q, sk_last_d;
  logic        busy_q, busy_d;
  logic        key_err_q, key_err_d;

  logic [55:0] pc1_s;
  logic [27:0] load_c_s, load_d_s;
  logic [27:0] adv_c_s, adv_d_s;
  logic        adv_two_s;

  // Load and advance candidates for C/D.
  always_comb begin
    pc1_s = pc1_perm(key_in);
    // Encrypt folds round 1's single left rotation into the load; decrypt
    // starts from C0/D0 because 28 total rotations give back the same halves.
    if (decrypt) begin
      load_c_s = pc1_s[55:28];
      load_d_s = pc1_s[27:0];
    end else begin
      load_c_s = rotl28(pc1_s[55:28], 1'b0);
      load_d_s = rotl28(pc1_s[27:0], 1'b0);
    end
    // Encrypt moves to round r+1 with that round's shift; decrypt undoes the
    // shift of the current round r.
    if (dec_q) begin
      adv_two_s = shift_is_two(round_idx_q);
      adv_c_s   = rotr28(c_q, adv_two_s);
      adv_d_s   = rotr28(d_q, adv_two_s);
    end else begin
      adv_two_s = shift_is_two(round_idx_q + 4'd1);
      adv_c_s   = rotl28(c_q, adv_two_s);
      adv_d_s   = rotl28(d_q, adv_two_s);
    end
  end

  // Next-state logic for the IDLE/PRESENT controller and output registers.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    d_d         = d_q;
    dec_d       = dec_q;
    cnt_d       = cnt_q;
    sk_valid_d  = sk_valid_q;
    subkey_d    = subkey_q;
    round_idx_d = round_idx_q;
    sk_last_d   = sk_last_q;
    busy_d      = busy_q;
    key_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (PARITY_CHECK && !key_parity_ok(key_in)) begin
            key_err_d = 1'b1;
          end else begin
            state_d     = ST_PRESENT;
            c_d         = load_c_s;
            d_d         = load_d_s;
            dec_d       = decrypt;
            cnt_d       = 4'd0;
            sk_valid_d  = 1'b1;
            busy_d      = 1'b1;
            subkey_d    = pc2_perm({load_c_s, load_d_s});
            round_idx_d = decrypt ? 4'd15 : 4'd0;
            sk_last_d   = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (sk_valid_q && sk_ready) begin
          if (cnt_q == 4'd15) begin
            state_d    = ST_IDLE;
            sk_valid_d = 1'b0;
            busy_d     = 1'b0;
            sk_last_d  = 1'b0;
          end else begin
            c_d         = adv_c_s;
            d_d         = adv_d_s;
            cnt_d       = cnt_q + 4'd1;
            subkey_d    = pc2_perm({adv_c_s, adv_d_s});
            round_idx_d = dec_q ? (round_idx_q - 4'd1) : (round_idx_q + 4'd1);
            sk_last_d   = (cnt_q == 4'd14);
          end
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        sk_valid_d = 1'b0;
        busy_d     = 1'b0;
        sk_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      c_q         <= 28'd0;
      d_q         <= 28'd0;
      dec_q       <= 1'b0;
      cnt_q       <= 4'd0;
      sk_valid_q  <= 1'b0;
      subkey_q    <= 48'd0;
      round_idx_q <= 4'd0;
      sk_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      d_q         <= d_d;
      dec_q       <= dec_d;
      cnt_q       <= cnt_d;
      sk_valid_q  <= sk_valid_d;
      subkey_q    <= subkey_d;
      round_idx_q <= round_idx_d;
      sk_last_q   <= sk_last_d;
      busy_q      <= busy_d;
      key_err_q   <= key_err_d;
    end
  end

  assign sk_valid  = sk_valid_q;
  assign subkey    = subkey_q;
  assign round_idx = round_idx_q;
  assign sk_last   = sk_last_q;
  assign busy      = busy_q;
  assign key_err   = key_err_q;

endmodule
